// File: rtl/dcnn_pkg.sv
// Shared types and the saturating accumulate helper for the dcnn output drain path.
package dcnn_pkg;

    localparam int DCNN_DW    = 16;
    localparam int DCNN_LANES = 64;
    localparam int DCNN_DEPTH = 64;

    typedef struct packed {
        logic layer_end;
        logic last_pass;
        logic first;
    } row_task_t;

    typedef enum logic {F_IDLE, F_ROW} fill_state_e;
    typedef enum logic {D_IDLE, D_RUN} drain_state_e;

    // Sum in DW+1 bits; disagreement of the top two bits means the result left the DW range.
    function automatic logic [DCNN_DW-1:0] sat_add(input logic [DCNN_DW-1:0] a,
                                                   input logic [DCNN_DW-1:0] b);
        logic [DCNN_DW:0] s;
        s = {a[DCNN_DW-1], a} + {b[DCNN_DW-1], b};
        if (s[DCNN_DW] != s[DCNN_DW-1])
            sat_add = s[DCNN_DW] ? {1'b1, {(DCNN_DW-1){1'b0}}} : {1'b0, {(DCNN_DW-1){1'b1}}};
        else
            sat_add = s[DCNN_DW-1:0];
    endfunction

endpackage

// File: rtl/dcnn_out_drain_if.sv
// Row-task, psum-column and DRAM-write handshakes of the output drain path.
interface dcnn_out_drain_if
    import dcnn_pkg::*;
#(
    parameter int DW    = DCNN_DW,
    parameter int LANES = DCNN_LANES
);
    logic              row_task_vld;
    logic              row_task_rdy;
    row_task_t         row_task_data;
    logic              psum_vld;
    logic              psum_rdy;
    logic [LANES*DW-1:0] psum_data;
    logic              dram_w_vld;
    logic              dram_w_rdy;
    logic [DW-1:0]     dram_w_data;
    logic              dram_w_last;

    modport slave (
        input  row_task_vld, row_task_data, psum_vld, psum_data, dram_w_rdy,
        output row_task_rdy, psum_rdy, dram_w_vld, dram_w_data, dram_w_last
    );

    modport master (
        output row_task_vld, row_task_data, psum_vld, psum_data, dram_w_rdy,
        input  row_task_rdy, psum_rdy, dram_w_vld, dram_w_data, dram_w_last
    );
endinterface

// File: rtl/dcnn_lane_bank.sv
// One ping/pong bank: wide masked read-modify-write port for the fill side,
// narrow registered read port for the drain side.
module dcnn_lane_bank
    import dcnn_pkg::*;
#(
    parameter int DW    = DCNN_DW,
    parameter int LANES = DCNN_LANES,
    parameter int DEPTH = DCNN_DEPTH,
    parameter int LW    = $clog2(LANES),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                wr_en,
    input  logic [LANES-1:0]    wr_mask,
    input  logic [AW-1:0]       wr_addr,
    input  logic [LANES*DW-1:0] wr_data,
    input  logic                wr_accum,
    input  logic                rd_en,
    input  logic [LW-1:0]       rd_lane,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data
);

    logic [DW-1:0] mem [LANES][DEPTH];
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en)
            rd_data_d = mem[rd_lane][rd_addr];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    // Storage is deliberately unreset; the accumulate path reads the old word combinationally.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i])
                    mem[i][wr_addr] <= wr_accum ? sat_add(mem[i][wr_addr], wr_data[i*DW +: DW])
                                                : wr_data[i*DW +: DW];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dcnn_out_drain.sv
// Ping-pong output path: accumulate LANES-wide psum rows into alternating banks,
// then stream each full bank lane-major to DRAM with optional ReLU.
module dcnn_out_drain
    import dcnn_pkg::*;
#(
    parameter int DW        = DCNN_DW,
    parameter int LANES     = DCNN_LANES,
    parameter int LANE_BIT  = 7,
    parameter int DEPTH     = DCNN_DEPTH,
    parameter int DEPTH_BIT = 7
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [LANE_BIT-1:0]  cfg_para_out_num,
    input  logic [DEPTH_BIT-1:0] cfg_row_len,
    input  logic                 cfg_relu,
    output logic                 err_overflow,
    dcnn_out_drain_if.slave      bus
);

    localparam int LW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LANE_BIT-1:0]  N_MAX = LANE_BIT'(LANES);
    localparam logic [DEPTH_BIT-1:0] L_MAX = DEPTH_BIT'(DEPTH);

    fill_state_e  fill_state_q, fill_state_d;
    drain_state_e drain_state_q, drain_state_d;
    row_task_t    task_q, task_d;
    logic [DEPTH_BIT-1:0] fcol_q, fcol_d;
    logic [1:0] full_q, full_d;
    logic fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d;
    logic alive_q, alive_d, err_q, err_d;
    logic [1:0][LANE_BIT-1:0]  meta_n_q, meta_n_d;
    logic [1:0][DEPTH_BIT-1:0] meta_l_q, meta_l_d;
    logic [1:0] meta_relu_q, meta_relu_d, meta_le_q, meta_le_d;
    logic [LANE_BIT-1:0]  d_lane_q, d_lane_d;
    logic [DEPTH_BIT-1:0] d_col_q, d_col_d;
    logic issued_all_q, issued_all_d, out_vld_q, out_vld_d;
    logic out_final_q, out_final_d, out_last_q, out_last_d;

    logic task_rdy, psum_rdy, wr_en, fill_done, drain_release, issue, is_final;
    logic [LANES-1:0] wr_mask;
    logic [1:0][DW-1:0] rd_data;
    logic [LANE_BIT-1:0]  fill_n, dn;
    logic [DEPTH_BIT-1:0] fill_l, dl;
    logic [DW-1:0] word;

    assign fill_n = meta_n_q[fill_bank_q];
    assign fill_l = meta_l_q[fill_bank_q];
    assign dn     = meta_n_q[drain_bank_q];
    assign dl     = meta_l_q[drain_bank_q];

    always_comb begin
        fill_state_d = fill_state_q;
        task_d       = task_q;
        fcol_d       = fcol_q;
        fill_bank_d  = fill_bank_q;
        meta_n_d     = meta_n_q;
        meta_l_d     = meta_l_q;
        meta_relu_d  = meta_relu_q;
        meta_le_d    = meta_le_q;
        fill_done    = 1'b0;
        task_rdy     = 1'b0;
        psum_rdy     = 1'b0;
        wr_en        = 1'b0;
        case (fill_state_q)
            F_IDLE: begin
                task_rdy = alive_q && !full_q[fill_bank_q];
                if (bus.row_task_vld && task_rdy) begin
                    task_d       = bus.row_task_data;
                    fcol_d       = '0;
                    fill_state_d = F_ROW;
                    meta_n_d[fill_bank_q] = (cfg_para_out_num == '0 || cfg_para_out_num > N_MAX)
                                            ? N_MAX : cfg_para_out_num;
                    meta_l_d[fill_bank_q] = (cfg_row_len == '0 || cfg_row_len > L_MAX)
                                            ? L_MAX : cfg_row_len;
                    meta_relu_d[fill_bank_q] = cfg_relu;
                    meta_le_d[fill_bank_q]   = bus.row_task_data.layer_end;
                end
            end
            F_ROW: begin
                psum_rdy = 1'b1;
                if (bus.psum_vld) begin
                    wr_en = 1'b1;
                    if (fcol_q == fill_l - 1'b1) begin
                        fill_state_d = F_IDLE;
                        if (task_q.last_pass) begin
                            fill_done   = 1'b1;
                            fill_bank_d = !fill_bank_q;
                        end
                    end else begin
                        fcol_d = fcol_q + 1'b1;
                    end
                end
            end
            default: fill_state_d = F_IDLE;
        endcase
    end

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < LANES; i++)
            wr_mask[i] = (i < int'(fill_n));
    end

    // A new read is issued whenever the output register is empty or being consumed.
    always_comb begin
        drain_state_d = drain_state_q;
        d_lane_d      = d_lane_q;
        d_col_d       = d_col_q;
        issued_all_d  = issued_all_q;
        out_vld_d     = out_vld_q;
        out_final_d   = out_final_q;
        out_last_d    = out_last_q;
        drain_bank_d  = drain_bank_q;
        drain_release = 1'b0;
        issue         = 1'b0;
        is_final      = (d_lane_q == dn - 1'b1) && (d_col_q == dl - 1'b1);
        case (drain_state_q)
            D_IDLE: begin
                if (full_q[drain_bank_q]) begin
                    drain_state_d = D_RUN;
                    d_lane_d      = '0;
                    d_col_d       = '0;
                    issued_all_d  = 1'b0;
                end
            end
            D_RUN: begin
                if (out_vld_q && bus.dram_w_rdy) begin
                    out_vld_d   = 1'b0;
                    out_final_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_final_q) begin
                        drain_release = 1'b1;
                        drain_bank_d  = !drain_bank_q;
                        drain_state_d = D_IDLE;
                    end
                end
                if (!issued_all_q && (!out_vld_q || bus.dram_w_rdy)) begin
                    issue       = 1'b1;
                    out_vld_d   = 1'b1;
                    out_final_d = is_final;
                    out_last_d  = is_final && meta_le_q[drain_bank_q];
                    if (is_final) begin
                        issued_all_d = 1'b1;
                    end else if (d_col_q == dl - 1'b1) begin
                        d_col_d  = '0;
                        d_lane_d = d_lane_q + 1'b1;
                    end else begin
                        d_col_d = d_col_q + 1'b1;
                    end
                end
            end
            default: drain_state_d = D_IDLE;
        endcase
    end

    // Fill and drain never act on the same bank, so both flag updates can land together.
    always_comb begin
        full_d = full_q;
        if (drain_release)
            full_d[drain_bank_q] = 1'b0;
        if (fill_done)
            full_d[fill_bank_q] = 1'b1;
        err_d   = err_q | (bus.psum_vld & !psum_rdy);
        alive_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fill_state_q  <= F_IDLE;
            drain_state_q <= D_IDLE;
            task_q        <= '0;
            fcol_q        <= '0;
            full_q        <= '0;
            fill_bank_q   <= 1'b0;
            drain_bank_q  <= 1'b0;
            alive_q       <= 1'b0;
            err_q         <= 1'b0;
            meta_n_q      <= '0;
            meta_l_q      <= '0;
            meta_relu_q   <= '0;
            meta_le_q     <= '0;
            d_lane_q      <= '0;
            d_col_q       <= '0;
            issued_all_q  <= 1'b0;
            out_vld_q     <= 1'b0;
            out_final_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            fill_state_q  <= fill_state_d;
            drain_state_q <= drain_state_d;
            task_q        <= task_d;
            fcol_q        <= fcol_d;
            full_q        <= full_d;
            fill_bank_q   <= fill_bank_d;
            drain_bank_q  <= drain_bank_d;
            alive_q       <= alive_d;
            err_q         <= err_d;
            meta_n_q      <= meta_n_d;
            meta_l_q      <= meta_l_d;
            meta_relu_q   <= meta_relu_d;
            meta_le_q     <= meta_le_d;
            d_lane_q      <= d_lane_d;
            d_col_q       <= d_col_d;
            issued_all_q  <= issued_all_d;
            out_vld_q     <= out_vld_d;
            out_final_q   <= out_final_d;
            out_last_q    <= out_last_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dcnn_lane_bank #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH)) u_bank (
            .clk     (clk),
            .arst_n  (arst_n),
            .wr_en   (wr_en && (fill_bank_q == 1'(b))),
            .wr_mask (wr_mask),
            .wr_addr (fcol_q[AW-1:0]),
            .wr_data (bus.psum_data),
            .wr_accum(!task_q.first),
            .rd_en   (issue && (drain_bank_q == 1'(b))),
            .rd_lane (d_lane_q[LW-1:0]),
            .rd_addr (d_col_q[AW-1:0]),
            .rd_data (rd_data[b])
        );
    end

    assign word             = rd_data[drain_bank_q];
    assign bus.dram_w_data  = (meta_relu_q[drain_bank_q] && word[DW-1]) ? '0 : word;
    assign bus.dram_w_vld   = out_vld_q;
    assign bus.dram_w_last  = out_last_q;
    assign bus.row_task_rdy = task_rdy;
    assign bus.psum_rdy     = psum_rdy;
    assign err_overflow     = err_q;

endmodule
